// File: rtl/axis_2_native_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_2_native_buffer
// Brief    : AXI-Stream to native FWFT buffer, cut-through or store-and-forward.
// Revision : 1.0 - initial release
// ============================================================================
module axis_2_native_buffer #(
    parameter int STDataWidth   = 32,
    parameter int TidWidth      = 8,
    parameter int TdestWidth    = 8,
    parameter int FifoDepth     = 16,
    parameter int PacketMode    = 0,
    parameter int AlmostFullThr = FifoDepth - 2
) (
    input  logic                         aclk,
    input  logic                         rst,
    input  logic [TidWidth-1:0]          s_axis_tid,
    input  logic [TdestWidth-1:0]        s_axis_tdest,
    input  logic [STDataWidth-1:0]       s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [TidWidth-1:0]          m_native_tid,
    output logic [TdestWidth-1:0]        m_native_tdest,
    output logic [STDataWidth-1:0]       m_native_tdata,
    output logic                         m_native_tlast,
    output logic                         m_native_tvalid,
    input  logic                         m_native_tready,
    output logic [$clog2(FifoDepth):0]   occupancy,
    output logic                         almost_full,
    output logic [$clog2(FifoDepth):0]   pkt_count
);

    localparam int PTR_W = $clog2(FifoDepth);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TidWidth + TdestWidth + STDataWidth + 1;

    localparam logic [CNT_W-1:0] c_DEPTH  = CNT_W'(FifoDepth);
    localparam logic [CNT_W-1:0] c_AF_THR = CNT_W'(AlmostFullThr);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    // Storage carries no reset; validity is tracked by occupancy alone.
    logic [ENT_W-1:0] r_mem [FifoDepth];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_pkt;
    logic             r_tready;
    logic             r_drain;

    logic             w_wr;
    logic             w_rd;
    logic             w_wr_last;
    logic             w_rd_last;
    logic             w_tvalid;
    logic [ENT_W-1:0] w_head;
    logic [ENT_W-1:0] w_wr_entry;
    logic [CNT_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] w_pkt_nxt;

    assign w_head     = r_mem[r_rptr];
    assign w_wr_entry = {s_axis_tid, s_axis_tdest, s_axis_tdata, s_axis_tlast};

    assign w_wr      = s_axis_tvalid & r_tready;
    assign w_rd      = w_tvalid & m_native_tready;
    assign w_wr_last = w_wr & s_axis_tlast;
    assign w_rd_last = w_rd & w_head[0];

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_wr, w_rd})
            2'b10:   w_occ_nxt = r_occ + c_ONE;
            2'b01:   w_occ_nxt = r_occ - c_ONE;
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_comb begin
        w_pkt_nxt = r_pkt;
        case ({w_wr_last, w_rd_last})
            2'b10:   w_pkt_nxt = r_pkt + c_ONE;
            2'b01:   w_pkt_nxt = r_pkt - c_ONE;
            default: w_pkt_nxt = r_pkt;
        endcase
    end

    generate
        if (PacketMode != 0) begin : g_store_forward
            // A full buffer with no complete packet would deadlock; drain
            // releases it until the eventual tlast entry leaves.
            always_ff @(posedge aclk) begin
                if (rst) begin
                    r_drain <= 1'b0;
                end else if (w_rd_last) begin
                    r_drain <= 1'b0;
                end else if ((w_occ_nxt == c_DEPTH) && (w_pkt_nxt == '0)) begin
                    r_drain <= 1'b1;
                end
            end
            assign w_tvalid = (r_occ != '0) & ((r_pkt != '0) | r_drain);
        end else begin : g_cut_through
            assign r_drain  = 1'b0;
            assign w_tvalid = (r_occ != '0);
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_occ    <= '0;
            r_pkt    <= '0;
            r_tready <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_occ    <= w_occ_nxt;
            r_pkt    <= w_pkt_nxt;
            // Registered not-full keeps tready free of any input-to-output path.
            r_tready <= (w_occ_nxt != c_DEPTH);
        end
    end

    assign s_axis_tready   = r_tready;
    assign m_native_tvalid = w_tvalid;
    assign {m_native_tid, m_native_tdest, m_native_tdata, m_native_tlast} = w_head;
    assign occupancy       = r_occ;
    assign pkt_count       = r_pkt;
    assign almost_full     = (r_occ >= c_AF_THR);

endmodule
`default_nettype wire

// File: doc/axis_2_native_buffer.md
AXIS_2_NATIVE_BUFFER -- requirements
Module: axis_2_native_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- STDataWidth, 32, payload width in bits.
- TidWidth, 8, stream ID width.
- TdestWidth, 8, destination width.
- FifoDepth, 16, entries; power of two, >=2.
- PacketMode, 0, 0 = cut-through, 1 = store-and-forward.
- AlmostFullThr, FifoDepth-2, almost_full threshold in entries.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- aclk, in, 1, clock.
- rst, in, 1, reset.
- s_axis_tid, in, TidWidth, stream ID.
- s_axis_tdest, in, TdestWidth, destination.
- s_axis_tdata, in, STDataWidth, payload.
- s_axis_tvalid, in, 1, source valid.
- s_axis_tlast, in, 1, packet boundary.
- s_axis_tready, out, 1, buffer accepts.
- m_native_tid, out, TidWidth, head-entry stream ID.
- m_native_tdest, out, TdestWidth, head-entry destination.
- m_native_tdata, out, STDataWidth, head-entry payload.
- m_native_tlast, out, 1, head-entry boundary.
- m_native_tvalid, out, 1, head entry valid.
- m_native_tready, in, 1, sink accepts.
- occupancy, out, clog2(FifoDepth)+1, stored entries.
- almost_full, out, 1, occupancy >= AlmostFullThr.
- pkt_count, out, clog2(FifoDepth)+1, complete packets stored.
REQ-003 Reset SHALL be rst, synchronous, active-high; clock SHALL be aclk; all state SHALL update on the rising edge of aclk only.

Function
REQ-004 Write SHALL occur on s_axis_tvalid & s_axis_tready; the entry {tid, tdest, tdata, tlast} SHALL be stored at the write pointer.
REQ-005 s_axis_tready SHALL be !full, decoded from registered occupancy, with no combinational path from any input.
REQ-006 Read SHALL occur on m_native_tvalid & m_native_tready, popping the head entry.
REQ-007 Output SHALL be first-word-fall-through; the m_native_* data fields SHALL show the head entry whenever occupancy > 0.
REQ-008 In PacketMode=0, m_native_tvalid SHALL be (occupancy > 0); a word written in cycle N SHALL be valid at the output in cycle N+1.
REQ-009 In PacketMode=1, m_native_tvalid SHALL be (occupancy > 0) & (pkt_count > 0 | drain).
REQ-010 drain SHALL be set when occupancy reaches FifoDepth with pkt_count = 0, and cleared on the read of a tlast entry.
REQ-011 While m_native_tvalid=1 and m_native_tready=0, all m_native_* outputs SHALL hold stable.
REQ-012 Read and write pointers SHALL wrap modulo FifoDepth.
REQ-013 occupancy SHALL be +1 on write-only, -1 on read-only, and unchanged on simultaneous read and write.
REQ-014 pkt_count SHALL be +1 on a write with tlast, -1 on a read with tlast, and unchanged when both occur in the same cycle.
REQ-015 Full boundary: no write SHALL occur; a read in the same cycle SHALL raise s_axis_tready in the next cycle.
REQ-016 Empty boundary: no read SHALL occur; a simultaneous write SHALL NOT bypass to the output in the same cycle.
REQ-017 almost_full SHALL be registered-equivalent, i.e. decoded from registered occupancy.
REQ-018 m_native_* data fields SHALL be don't-care while m_native_tvalid=0.

Reset
REQ-019 While rst=1: pointers, occupancy, pkt_count and drain SHALL be 0; s_axis_tready=0; m_native_tvalid=0; almost_full=0.
REQ-020 s_axis_tready SHALL be 1 in the first cycle after rst deasserts.
REQ-021 rst asserted mid-transfer SHALL discard all stored entries; no stale entry SHALL appear after reset.
REQ-022 Storage array SHALL NOT require reset.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Mode 0, one write with tdata=0xA5, tid=3, tlast=1, sink ready -> m_native_tvalid=1 next cycle with the same fields; occupancy returns to 0 after the read.
- Depth 16, sink held low, 16 writes -> s_axis_tready=0 after the 16th; almost_full=1 at occupancy 14; one read -> s_axis_tready=1 next cycle.
- Continuous source and sink at 100% for 40 words -> pointers wrap twice; output sequence equals input sequence; occupancy constant.
- PacketMode=1, 4-word packet written with a 1-cycle gap per word -> m_native_tvalid stays 0 until after the tlast write, then 4 back-to-back reads.
- PacketMode=1, 16 words without tlast -> drain=1; m_native_tvalid=1; entries drain; a tlast write then completes normally.
- rst pulse with occupancy=5 -> occupancy=0, m_native_tvalid=0, pkt_count=0; next write is output first.
